// File: rtl/fetch_seq_pkg.sv
// Shared types for fetch_sequencer: FSM states, control opcodes and pcSrc encodings.
// The pcSrc encodings are also used by pc_block instantiations.
package fetch_seq_pkg;

    localparam int INSTR_W = 16;

    typedef enum logic [2:0] {
        FETCH    = 3'd0,
        DECODE   = 3'd1,
        DISPATCH = 3'd2,
        EXEC     = 3'd3,
        CMPWAIT  = 3'd4,
        UPDATE   = 3'd5
    } fetch_state_e;

    localparam logic [3:0] OP_J    = 4'h8;
    localparam logic [3:0] OP_BR   = 4'h9;
    localparam logic [3:0] OP_JAL  = 4'hA;
    localparam logic [3:0] OP_JR   = 4'hB;
    localparam logic [3:0] OP_JM   = 4'hC;
    localparam logic [3:0] OP_JMS  = 4'hD;
    localparam logic [3:0] OP_CABS = 4'hE;
    localparam logic [3:0] OP_CREL = 4'hF;

    localparam logic [2:0] PCSRC_SEQ  = 3'b000;
    localparam logic [2:0] PCSRC_BR   = 3'b001;
    localparam logic [2:0] PCSRC_ABS  = 3'b010;
    localparam logic [2:0] PCSRC_JR   = 3'b011;
    localparam logic [2:0] PCSRC_JM   = 3'b100;
    localparam logic [2:0] PCSRC_JMS  = 3'b101;
    localparam logic [2:0] PCSRC_CABS = 3'b110;
    localparam logic [2:0] PCSRC_CREL = 3'b111;

    function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] w);
        return w[INSTR_W-1:INSTR_W-4];
    endfunction

endpackage

// File: rtl/fetch_decode.sv
// fetch_decode: combinational classification of the instruction register into
// control flags, pcSrc select and zero/sign-extended immediates.
module fetch_decode
    import fetch_seq_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int IMM_W  = 12
) (
    input  logic [INSTR_W-1:0] ir_i,
    output logic               is_ctrl_o,
    output logic               is_cond_o,
    output logic               is_link_o,
    output logic [2:0]         pc_src_o,
    output logic [ADDR_W-1:0]  imm_addr_o,
    output logic [ADDR_W-1:0]  se_imm_addr_o
);

    logic [3:0] op;

    assign op = opcode_of(ir_i);

    always_comb begin
        pc_src_o  = PCSRC_SEQ;
        is_link_o = 1'b0;
        case (op)
            OP_J:    pc_src_o = PCSRC_ABS;
            OP_BR:   pc_src_o = PCSRC_BR;
            OP_JAL: begin
                pc_src_o  = PCSRC_ABS;
                is_link_o = 1'b1;
            end
            OP_JR:   pc_src_o = PCSRC_JR;
            OP_JM:   pc_src_o = PCSRC_JM;
            OP_JMS:  pc_src_o = PCSRC_JMS;
            OP_CABS: pc_src_o = PCSRC_CABS;
            OP_CREL: pc_src_o = PCSRC_CREL;
            default: pc_src_o = PCSRC_SEQ;
        endcase
    end

    // Opcodes 0x8-0xF all have the top bit set; 0xE/0xF are the compare-gated pair.
    assign is_ctrl_o = op[3];
    assign is_cond_o = (op == OP_CABS) || (op == OP_CREL);

    assign imm_addr_o    = {{(ADDR_W-IMM_W){1'b0}}, ir_i[IMM_W-1:0]};
    assign se_imm_addr_o = {{(ADDR_W-IMM_W){ir_i[IMM_W-1]}}, ir_i[IMM_W-1:0]};

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: FETCH/DECODE/DISPATCH/EXEC/CMPWAIT/UPDATE sequencer feeding pc_block.
// Define LINK_REG_EN to build the JAL link register; otherwise ra is tied to 0.
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int IMM_W  = 12
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pcOut,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_ack,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               exec_done,
    input  logic               cmp_valid,
    output logic [2:0]         pcSrc,
    output logic               pcWrite,
    output logic [ADDR_W-1:0]  immAddr,
    output logic [ADDR_W-1:0]  se_immAddr,
    output logic [ADDR_W-1:0]  ra,
    output logic [2:0]         dbg_state
);

    fetch_state_e       state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               run_q;
    logic               is_ctrl, is_cond, is_link;

    fetch_decode #(
        .ADDR_W (ADDR_W),
        .IMM_W  (IMM_W)
    ) u_decode (
        .ir_i          (ir_q),
        .is_ctrl_o     (is_ctrl),
        .is_cond_o     (is_cond),
        .is_link_o     (is_link),
        .pc_src_o      (pcSrc),
        .imm_addr_o    (immAddr),
        .se_imm_addr_o (se_immAddr)
    );

    // Handshakes: a transfer happens on a rising edge where the request/valid
    // output and the matching ack/ready input are both high; inputs seen in any
    // other state are ignored. run_q keeps imem_req low until the first edge after reset.
    always_comb begin
        imem_req    = run_q && (state_q == FETCH);
        instr_valid = (state_q == DISPATCH);
        pcWrite     = (state_q == UPDATE);
        state_d     = state_q;
        ir_d        = ir_q;
        case (state_q)
            FETCH: begin
                if (imem_req && imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (!is_ctrl)     state_d = DISPATCH;
                else if (is_cond) state_d = CMPWAIT;
                else              state_d = UPDATE;
            end
            DISPATCH: if (instr_ready) state_d = EXEC;
            EXEC:     if (exec_done)   state_d = UPDATE;
            CMPWAIT:  if (cmp_valid)   state_d = UPDATE;
            UPDATE:   state_d = FETCH;
            default:  state_d = FETCH;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            ir_q    <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            run_q   <= 1'b1;
        end
    end

    assign imem_addr = pcOut;
    assign instr     = ir_q;
    assign dbg_state = state_q;

`ifdef LINK_REG_EN
    logic [ADDR_W-1:0] ra_q, ra_d;

    // Link is taken from the PC before the UPDATE edge loads the jump target.
    always_comb begin
        ra_d = ra_q;
        if ((state_q == UPDATE) && is_link) ra_d = pcOut + ADDR_W'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) ra_q <= '0;
        else       ra_q <= ra_d;
    end

    assign ra = ra_q;
`else
    logic unused_link;

    assign unused_link = is_link;
    assign ra          = '0;
`endif

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Multi-cycle fetch/control sequencer that drives `pc_block`. It reads the instruction at `pcOut` over a req/ack instruction-memory port, latches it into an instruction register, and classifies it. Non-control instructions are dispatched to the datapath; control instructions are resolved locally. It then issues exactly one `pcWrite` pulse with the matching `pcSrc`, `immAddr`, `se_immAddr` and `ra`.

## Interface
Parameters:
- `ADDR_W`, 16, PC/address width; must match `pc_block`.
- `IMM_W`, 12, immediate field width, `ir[IMM_W-1:0]`.

Ports:
- `clock`  in  1  single system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high; forces reset state immediately.
- `pcOut`  in  16  current PC from `pc_block`.
- `imem_req`  out  1  instruction read request.
- `imem_addr`  out  16  read address, equals `pcOut` while `imem_req`=1.
- `imem_rdata`  in  16  instruction word, valid when `imem_ack`=1.
- `imem_ack`  in  1  read complete.
- `instr`  out  16  latched instruction register `ir`.
- `instr_valid`  out  1  non-control instruction offered to the datapath.
- `instr_ready`  in  1  datapath accepts `instr`.
- `exec_done`  in  1  datapath has finished the dispatched instruction.
- `cmp_valid`  in  1  datapath `comp` is valid for the current conditional.
- `pcSrc`  out  3  next-PC select to `pc_block`.
- `pcWrite`  out  1  one-cycle PC update strobe.
- `immAddr`  out  16  `ir[11:0]` zero-extended.
- `se_immAddr`  out  16  `ir[11:0]` sign-extended from bit 11.
- `ra`  out  16  link register.

## Operation
- Opcode is `ir[15:12]`.
- Opcodes 0x0–0x7 are non-control.
- Control opcode → `pcSrc`:
  - 0x8 J → 010
  - 0x9 BR → 001
  - 0xA JAL → 010 plus link
  - 0xB JR → 011
  - 0xC JM → 100
  - 0xD JMS → 101
  - 0xE conditional absolute → 110
  - 0xF conditional relative → 111
- `comp` gating for 110/111 is done inside `pc_block`. This block always pulses `pcWrite` for those opcodes once `cmp_valid` is seen.
- States:
  - FETCH: `imem_req`=1. On `imem_ack`, latch `ir`=`imem_rdata` → DECODE.
  - DECODE: non-control → DISPATCH; opcode 0xE/0xF → CMPWAIT; other control opcodes → UPDATE.
  - DISPATCH: `instr_valid`=1 until `instr_ready` → EXEC.
  - EXEC: wait for `exec_done` → UPDATE. In this path `pcSrc`=000.
  - CMPWAIT: wait for `cmp_valid` → UPDATE.
  - UPDATE: `pcWrite`=1 for exactly one cycle → FETCH.
- JAL: `ra` ← `pcOut`+1 (mod 2^16) on the UPDATE edge, the same edge the PC loads. `pcOut`+1 is computed from the old PC, so 0xFFFF links to 0x0000.
- Outputs are Moore: decoded from the state register and `ir` only. There are no combinational input→output paths except `imem_addr`=`pcOut`.
- Inputs outside their state are ignored: `imem_ack` outside FETCH, `instr_ready` outside DISPATCH, `exec_done` outside EXEC, `cmp_valid` outside CMPWAIT.
- `pcSrc`/`immAddr`/`se_immAddr` are held stable from DECODE through UPDATE.

## Timing
- Reset values:
  - state = FETCH.
  - `ir`, `ra` = 0.
  - `imem_req`, `instr_valid`, `pcWrite` = 0.
  - `pcSrc` = 000.
- `imem_req` rises in the first cycle after `reset` deasserts.
- `imem_ack` in the same cycle as the request is legal.
- Minimum latency for an unconditional jump: 3 cycles (FETCH, DECODE, UPDATE).
- Minimum latency for a non-control instruction: 5 cycles. This assumes `instr_ready` and `exec_done` each arrive on the first cycle of their state.
- Reset mid-operation: immediate return to FETCH with `imem_req` and `instr_valid` dropped. Memory and datapath must tolerate an aborted transaction. `ra` is cleared.
- Exactly one `pcWrite` pulse per fetched instruction; never two in consecutive cycles.

## Configuration
- `LINK_REG_EN` defined: JAL captures the link as described.
- `LINK_REG_EN` undefined:
  - `ra` register is removed.
  - `ra` output is tied to 0.
  - JAL behaves exactly as J.
  - JR (0xB) still drives `pcSrc`=011.

## Structure
- Shared package `fetch_seq_pkg` holds:
  - state enum {FETCH, DECODE, DISPATCH, EXEC, CMPWAIT, UPDATE};
  - opcode constants 0x8–0xF;
  - `pcSrc` encodings 000–111, shared with `pc_block` users.
- One natural sub-module: `fetch_decode`. It is combinational and maps `ir` to {`is_ctrl`, `is_cond`, `is_link`, `pcSrc`, `immAddr`, `se_immAddr`}.

## Test plan
- Reset, then `imem_ack` 2 cycles after req with `imem_rdata`=0x8123 → `pcWrite` one cycle with `pcSrc`=010 and `immAddr`=0x0123, then FETCH.
- `pcOut`=0x0040, instr 0x9FFE → `se_immAddr`=0xFFFE, `pcSrc`=001, single `pcWrite`.
- `pcOut`=0xFFFF, JAL 0xA010 with `LINK_REG_EN` → `ra`=0x0000 after UPDATE. Without `LINK_REG_EN` → `ra` stays 0 and `pcSrc`=010.
- Instr 0x3456 with `instr_ready` delayed 3 cycles and `exec_done` delayed 4 cycles → `instr_valid` held until accept, then `pcWrite` with `pcSrc`=000, exactly once.
- Instr 0xE020 with `cmp_valid` after 5 cycles → `pcWrite` in the cycle after `cmp_valid`, `pcSrc`=110. A spurious `cmp_valid` during FETCH is ignored.
- Assert `reset` during DISPATCH → `instr_valid`=0 and `pcWrite`=0 immediately; `imem_req`=1 in the first cycle after release.
